// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-side signals of the SCPU memory port arbiter.
// The slave modport is the arbiter; the master modport is the requesters plus the memory.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_ack;
    logic [DW-1:0] if_rdata;
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_ack;
    logic [DW-1:0] dm_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-3:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;
    logic          prot_fault;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_ack, if_rdata, dm_ack, dm_rdata, mem_en, mem_we, mem_addr,
               mem_wdata, busy, prot_fault
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_ack, if_rdata, dm_ack, dm_rdata, mem_en, mem_we, mem_addr,
               mem_wdata, busy, prot_fault
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and load/store requesters onto one word-addressed memory, one access at a time.
// Optional macro MEM_ARB_PROTECT_EN blocks stores below TEXT_LIMIT and raises a sticky prot_fault.
module mem_port_arbiter #(
    parameter int            AW         = 32,
    parameter int            DW         = 32,
    parameter int            MEM_LAT    = 1,
    parameter logic [AW-1:0] TEXT_LIMIT = AW'(32'h2000)
) (
    input  logic               clk,
    input  logic               reset,
    mem_port_arbiter_if.slave  bus
);

`ifdef MEM_ARB_PROTECT_EN
    localparam bit PROTECT = 1'b1;
`else
    localparam bit PROTECT = 1'b0;
`endif

    localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t        state_r;
    logic [2:0]    wait_cnt_r;
    logic          owner_dm_r;
    logic          last_dm_r;
    logic          we_r;
    logic [AW-3:0] addr_r;
    logic [DW-1:0] wdata_r;
    logic [DW-1:0] if_rdata_r;
    logic [DW-1:0] dm_rdata_r;
    logic          if_ack_r;
    logic          dm_ack_r;
    logic          mem_en_r;
    logic          mem_we_r;
    logic          busy_r;
    logic          prot_fault_r;

    logic          grant_s;
    logic          pick_dm_s;
    logic          blocked_s;

    // Grant selection: a lone request wins, contention goes to whoever did not win last.
    always_comb begin
        grant_s   = 1'b0;
        pick_dm_s = 1'b0;
        blocked_s = 1'b0;
        if (bus.if_req && bus.dm_req) begin
            grant_s   = 1'b1;
            pick_dm_s = ~last_dm_r;
        end else if (bus.dm_req) begin
            grant_s   = 1'b1;
            pick_dm_s = 1'b1;
        end else if (bus.if_req) begin
            grant_s   = 1'b1;
            pick_dm_s = 1'b0;
        end else begin
            grant_s   = 1'b0;
            pick_dm_s = 1'b0;
        end
        if (PROTECT && pick_dm_s && bus.dm_we && (bus.dm_addr < TEXT_LIMIT)) begin
            blocked_s = 1'b1;
        end else begin
            blocked_s = 1'b0;
        end
    end

    // Access sequencer: IDLE -> ISSUE -> WAIT (loads/fetches only) -> DONE, all outputs registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            wait_cnt_r   <= 3'd0;
            owner_dm_r   <= 1'b0;
            last_dm_r    <= 1'b0;
            we_r         <= 1'b0;
            addr_r       <= '0;
            wdata_r      <= '0;
            if_rdata_r   <= '0;
            dm_rdata_r   <= '0;
            if_ack_r     <= 1'b0;
            dm_ack_r     <= 1'b0;
            mem_en_r     <= 1'b0;
            mem_we_r     <= 1'b0;
            busy_r       <= 1'b0;
            prot_fault_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if_ack_r <= 1'b0;
                    dm_ack_r <= 1'b0;
                    if (grant_s) begin
                        owner_dm_r   <= pick_dm_s;
                        last_dm_r    <= pick_dm_s;
                        we_r         <= pick_dm_s & bus.dm_we;
                        addr_r       <= pick_dm_s ? bus.dm_addr[AW-1:2] : bus.if_addr[AW-1:2];
                        wdata_r      <= pick_dm_s ? bus.dm_wdata : wdata_r;
                        mem_en_r     <= ~blocked_s;
                        mem_we_r     <= pick_dm_s & bus.dm_we & ~blocked_s;
                        prot_fault_r <= prot_fault_r | blocked_s;
                        busy_r       <= 1'b1;
                        state_r      <= ST_ISSUE;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    mem_en_r <= 1'b0;
                    mem_we_r <= 1'b0;
                    if (we_r) begin
                        dm_ack_r <= 1'b1;
                        state_r  <= ST_DONE;
                    end else begin
                        wait_cnt_r <= LAT_M1;
                        state_r    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt_r == 3'd0) begin
                        if (owner_dm_r) begin
                            dm_rdata_r <= bus.mem_rdata;
                            dm_ack_r   <= 1'b1;
                        end else begin
                            if_rdata_r <= bus.mem_rdata;
                            if_ack_r   <= 1'b1;
                        end
                        state_r <= ST_DONE;
                    end else begin
                        wait_cnt_r <= wait_cnt_r - 3'd1;
                    end
                end
                ST_DONE: begin
                    if_ack_r <= 1'b0;
                    dm_ack_r <= 1'b0;
                    busy_r   <= 1'b0;
                    state_r  <= ST_IDLE;
                end
                default: begin
                    if_ack_r <= 1'b0;
                    dm_ack_r <= 1'b0;
                    mem_en_r <= 1'b0;
                    mem_we_r <= 1'b0;
                    busy_r   <= 1'b0;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.if_ack     = if_ack_r;
    assign bus.if_rdata   = if_rdata_r;
    assign bus.dm_ack     = dm_ack_r;
    assign bus.dm_rdata   = dm_rdata_r;
    assign bus.mem_en     = mem_en_r;
    assign bus.mem_we     = mem_we_r;
    assign bus.mem_addr   = addr_r;
    assign bus.mem_wdata  = wdata_r;
    assign bus.busy       = busy_r;
    assign bus.prot_fault = prot_fault_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of grant order, ack timing and memory contents.
module tb_mem_port_arbiter;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LAT = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT), .TEXT_LIMIT(32'h2000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Memory environment: writes on mem_we, read data appears LAT cycles after the mem_en cycle.
    logic [31:0] mem     [0:4095];
    logic [31:0] ref_mem [0:4095];
    logic [31:0] pipe    [0:LAT-1];

    always @(posedge clk) begin
        if (bus.mem_en && bus.mem_we) mem[bus.mem_addr[11:0]] <= bus.mem_wdata;
        pipe[0] <= (bus.mem_en && !bus.mem_we) ? mem[bus.mem_addr[11:0]] : 32'hBAD0_BAD0;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign bus.mem_rdata = pipe[LAT-1];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    bit          last_dm   = 1'b0;
    logic [31:0] exp_if    = 32'h0;
    logic [31:0] exp_dm    = 32'h0;
    bit          exp_fault = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.if_req   = 1'b0;
        bus.if_addr  = 32'h0;
        bus.dm_req   = 1'b0;
        bus.dm_we    = 1'b0;
        bus.dm_addr  = 32'h0;
        bus.dm_wdata = 32'h0;
    endtask

    task automatic model_reset();
        last_dm   = 1'b0;
        exp_if    = 32'h0;
        exp_dm    = 32'h0;
        exp_fault = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        idle_inputs();
        tick();
        tick();
        reset = 1'b1;
        model_reset();
        tick();
    endtask

    function automatic bit is_blocked(input bit dm, input bit we, input logic [31:0] addr);
`ifdef MEM_ARB_PROTECT_EN
        return dm && we && (addr < 32'h2000);
`else
        return 1'b0;
`endif
    endfunction

    // One solo access with full cycle-by-cycle checking; optional address/data scramble after grant.
    task automatic do_access(input bit dm, input bit we, input logic [31:0] addr,
                             input logic [31:0] wdata, input bit scramble, input string name);
        int   exp_cyc;
        bit   blocked;
        bit   done;
        logic exp_en;
        blocked = is_blocked(dm, we, addr);
        exp_cyc = (dm && we) ? 2 : LAT + 2;
        if (!dm) exp_if = ref_mem[addr[13:2]];
        else if (!we) exp_dm = ref_mem[addr[13:2]];
        else if (!blocked) ref_mem[addr[13:2]] = wdata;
        exp_fault = exp_fault | blocked;
        last_dm   = dm;
        if (dm) begin
            bus.dm_req = 1'b1; bus.dm_we = we; bus.dm_addr = addr; bus.dm_wdata = wdata;
        end else begin
            bus.if_req = 1'b1; bus.if_addr = addr;
        end
        done = 1'b0;
        for (int c = 1; c <= LAT + 6 && !done; c++) begin
            tick();
            if (c == 1 && scramble) begin
                bus.if_addr = addr + 32'd4; bus.dm_addr = addr + 32'd4; bus.dm_wdata = ~wdata;
            end
            exp_en = (c == 1) && !blocked;
            n_tests++;
            if (bus.mem_en !== exp_en) begin
                n_fail++; $display("FAIL %s mem_en c%0d: got %b want %b", name, c, bus.mem_en, exp_en);
            end
            if (c == 1) begin
                n_tests++;
                if (bus.mem_addr !== addr[31:2]) begin
                    n_fail++; $display("FAIL %s mem_addr: got %h want %h", name, bus.mem_addr, addr[31:2]);
                end
                n_tests++;
                if (bus.mem_we !== (we && !blocked)) begin
                    n_fail++; $display("FAIL %s mem_we: got %b want %b", name, bus.mem_we, we && !blocked);
                end
                if (dm && we && !blocked) begin
                    n_tests++;
                    if (bus.mem_wdata !== wdata) begin
                        n_fail++; $display("FAIL %s mem_wdata: got %h want %h", name, bus.mem_wdata, wdata);
                    end
                end
            end
            n_tests++;
            if (bus.busy !== 1'b1) begin
                n_fail++; $display("FAIL %s busy c%0d: got %b want 1", name, c, bus.busy);
            end
            n_tests++;
            if ((dm ? bus.if_ack : bus.dm_ack) !== 1'b0) begin
                n_fail++; $display("FAIL %s wrong_ack c%0d: got 1 want 0", name, c);
            end
            if ((dm ? bus.dm_ack : bus.if_ack) === 1'b1) begin
                done = 1'b1;
                n_tests++;
                if (c != exp_cyc) begin
                    n_fail++; $display("FAIL %s ack_cycle: got %0d want %0d", name, c, exp_cyc);
                end
                n_tests++;
                if (bus.if_rdata !== exp_if || bus.dm_rdata !== exp_dm) begin
                    n_fail++; $display("FAIL %s rdata: got if=%h dm=%h want if=%h dm=%h",
                                       name, bus.if_rdata, bus.dm_rdata, exp_if, exp_dm);
                end
                n_tests++;
                if (bus.prot_fault !== exp_fault) begin
                    n_fail++; $display("FAIL %s prot_fault: got %b want %b", name, bus.prot_fault, exp_fault);
                end
                idle_inputs();
                tick();
                n_tests++;
                if (bus.busy !== 1'b0 || bus.if_ack !== 1'b0 || bus.dm_ack !== 1'b0) begin
                    n_fail++; $display("FAIL %s after_done: got busy=%b acks=%b%b want 0 00",
                                       name, bus.busy, bus.if_ack, bus.dm_ack);
                end
            end
        end
        if (!done) begin
            n_tests++; n_fail++;
            $display("FAIL %s timeout: got no ack want ack at cycle %0d", name, exp_cyc);
            idle_inputs();
            tick();
        end
    endtask

    task automatic test_reset();
        logic [255:0] outs;
        reset = 1'b0;
        idle_inputs();
        #20;
        outs = 256'({bus.if_ack, bus.if_rdata, bus.dm_ack, bus.dm_rdata, bus.mem_en, bus.mem_we,
                     bus.mem_addr, bus.mem_wdata, bus.busy, bus.prot_fault});
        n_tests++;
        if (outs !== 256'h0) begin
            n_fail++; $display("FAIL reset_outputs: got %h want 0", outs);
        end
        do_reset();
        n_tests++;
        if (bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle_busy: got %b want 0", bus.busy);
        end
    endtask

    task automatic test_fetch();
        do_access(1'b0, 1'b0, 32'h0000_0004, 32'h0, 1'b0, "fetch_word1");
        n_tests++;
        if (bus.if_rdata !== 32'h2008_0005) begin
            n_fail++; $display("FAIL fetch_value: got %h want 20080005", bus.if_rdata);
        end
    endtask

    task automatic test_store_load();
        do_access(1'b1, 1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 1'b0, "store_2000");
        do_access(1'b1, 1'b0, 32'h0000_2000, 32'h0, 1'b0, "load_2000");
        n_tests++;
        if (bus.dm_rdata !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL load_value: got %h want deadbeef", bus.dm_rdata);
        end
        do_access(1'b1, 1'b0, 32'h0000_2007, 32'h0, 1'b0, "load_byteoff");
    endtask

    task automatic test_contention();
        int acks;
        int cyc;
        int next_cyc;
        bit want_dm;
        do_reset();
        bus.if_req = 1'b1; bus.if_addr = 32'h8;
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h2004;
        acks = 0; cyc = 0; next_cyc = LAT + 2;
        while (acks < 4 && cyc < 100) begin
            tick();
            cyc++;
            n_tests++;
            if (bus.if_ack === 1'b1 && bus.dm_ack === 1'b1) begin
                n_fail++; $display("FAIL contention_overlap c%0d: got both acks want one", cyc);
            end
            if (bus.if_ack === 1'b1 || bus.dm_ack === 1'b1) begin
                want_dm = !last_dm;
                if (want_dm) exp_dm = ref_mem[2049]; else exp_if = ref_mem[2];
                last_dm = want_dm;
                n_tests++;
                if (bus.dm_ack !== want_dm) begin
                    n_fail++; $display("FAIL contention_order #%0d: got dm_ack=%b want %b", acks, bus.dm_ack, want_dm);
                end
                n_tests++;
                if (cyc != next_cyc) begin
                    n_fail++; $display("FAIL contention_cycle #%0d: got %0d want %0d", acks, cyc, next_cyc);
                end
                n_tests++;
                if (bus.if_rdata !== exp_if || bus.dm_rdata !== exp_dm) begin
                    n_fail++; $display("FAIL contention_data #%0d: got if=%h dm=%h want if=%h dm=%h",
                                       acks, bus.if_rdata, bus.dm_rdata, exp_if, exp_dm);
                end
                next_cyc = cyc + LAT + 3;
                acks++;
                if (acks == 4) idle_inputs();
            end
        end
        if (acks < 4) begin
            n_tests++; n_fail++;
            $display("FAIL contention_timeout: got %0d acks want 4", acks);
            idle_inputs();
        end
        tick();
    endtask

    task automatic test_addr_change();
        do_access(1'b0, 1'b0, 32'h0000_0004, 32'h0, 1'b1, "fetch_scramble");
        do_access(1'b1, 1'b1, 32'h0000_2010, 32'h1234_5678, 1'b1, "store_scramble");
        do_access(1'b1, 1'b0, 32'h0000_2010, 32'h0, 1'b1, "load_scramble");
    endtask

    task automatic test_reset_midflight();
        logic [255:0] outs;
        bus.if_req = 1'b1; bus.if_addr = 32'h4;
        tick();
        tick();
        reset = 1'b0;
        #1;
        outs = 256'({bus.if_ack, bus.if_rdata, bus.dm_ack, bus.dm_rdata, bus.mem_en, bus.mem_we,
                     bus.mem_addr, bus.mem_wdata, bus.busy, bus.prot_fault});
        n_tests++;
        if (outs !== 256'h0) begin
            n_fail++; $display("FAIL midflight_reset_outputs: got %h want 0", outs);
        end
        idle_inputs();
        tick();
        reset = 1'b1;
        model_reset();
        for (int c = 0; c < LAT + 4; c++) begin
            tick();
            n_tests++;
            if (bus.if_ack !== 1'b0 || bus.busy !== 1'b0) begin
                n_fail++; $display("FAIL midflight_no_ack c%0d: got ack=%b busy=%b want 0 0", c, bus.if_ack, bus.busy);
            end
        end
        do_access(1'b0, 1'b0, 32'h0000_0004, 32'h0, 1'b0, "refetch_after_reset");
    endtask

    task automatic test_protect();
        do_access(1'b1, 1'b1, 32'h0000_0010, 32'hCAFE_F00D, 1'b0, "store_text");
        do_access(1'b0, 1'b0, 32'h0000_0010, 32'h0, 1'b0, "fetch_after_text_store");
        do_access(1'b1, 1'b1, 32'h0000_2020, 32'h0BAD_CAFE, 1'b0, "store_data_region");
        do_reset();
        n_tests++;
        if (bus.prot_fault !== 1'b0) begin
            n_fail++; $display("FAIL prot_fault_cleared: got %b want 0", bus.prot_fault);
        end
    endtask

    // Random single and contending transactions; the model orders them and predicts ack cycles/data.
    task automatic test_random();
        for (int it = 0; it < 40; it++) begin
            bit          f, d, dwe, first_dm, blocked, f_done, d_done;
            logic [31:0] fa, da, dwd;
            int          ack_if, ack_dm, t;
            logic [31:0] snap_if_at_if, snap_dm_at_if, snap_if_at_dm, snap_dm_at_dm;
            f   = 1'($urandom_range(0, 1));
            d   = 1'($urandom_range(0, 1));
            if (!f && !d) d = 1'b1;
            fa  = (32'($urandom_range(0, 63)) << 2) + 32'($urandom_range(0, 3));
            da  = ($urandom_range(0, 1) == 1 ? 32'h2000 : 32'h0) + (32'($urandom_range(0, 63)) << 2)
                  + 32'($urandom_range(0, 3));
            dwe = 1'($urandom_range(0, 1));
            dwd = $urandom();
            blocked  = is_blocked(1'b1, dwe, da);
            first_dm = d && (!f || !last_dm);
            t = 0; ack_if = 0; ack_dm = 0;
            for (int k = 0; k < 2; k++) begin
                bit serve_dm;
                serve_dm = (k == 0) ? first_dm : !first_dm;
                if (serve_dm && d) begin
                    if (!dwe) exp_dm = ref_mem[da[13:2]];
                    else if (!blocked) ref_mem[da[13:2]] = dwd;
                    exp_fault = exp_fault | blocked;
                    ack_dm = t + 2 + (dwe ? 0 : LAT);
                    t = ack_dm + 1;
                    snap_if_at_dm = exp_if; snap_dm_at_dm = exp_dm;
                    last_dm = 1'b1;
                end else if (!serve_dm && f) begin
                    exp_if = ref_mem[fa[13:2]];
                    ack_if = t + 2 + LAT;
                    t = ack_if + 1;
                    snap_if_at_if = exp_if; snap_dm_at_if = exp_dm;
                    last_dm = 1'b0;
                end
            end
            bus.if_req = f; bus.if_addr = fa;
            bus.dm_req = d; bus.dm_we = dwe; bus.dm_addr = da; bus.dm_wdata = dwd;
            f_done = !f; d_done = !d;
            for (int c = 1; c < 3 * LAT + 12 && !(f_done && d_done); c++) begin
                tick();
                n_tests++;
                if (bus.if_ack === 1'b1 && bus.dm_ack === 1'b1) begin
                    n_fail++; $display("FAIL rnd%0d overlap c%0d: got both acks want one", it, c);
                end
                if (bus.if_ack === 1'b1) begin
                    n_tests++;
                    if (f_done || c != ack_if || bus.if_rdata !== snap_if_at_if || bus.dm_rdata !== snap_dm_at_if) begin
                        n_fail++; $display("FAIL rnd%0d if_ack: got c%0d if=%h dm=%h want c%0d if=%h dm=%h (pending %b)",
                                           it, c, bus.if_rdata, bus.dm_rdata, ack_if, snap_if_at_if, snap_dm_at_if, !f_done);
                    end
                    f_done = 1'b1; bus.if_req = 1'b0;
                end
                if (bus.dm_ack === 1'b1) begin
                    n_tests++;
                    if (d_done || c != ack_dm || bus.if_rdata !== snap_if_at_dm || bus.dm_rdata !== snap_dm_at_dm
                        || bus.prot_fault !== exp_fault) begin
                        n_fail++; $display("FAIL rnd%0d dm_ack: got c%0d if=%h dm=%h pf=%b want c%0d if=%h dm=%h pf=%b",
                                           it, c, bus.if_rdata, bus.dm_rdata, bus.prot_fault,
                                           ack_dm, snap_if_at_dm, snap_dm_at_dm, exp_fault);
                    end
                    d_done = 1'b1; bus.dm_req = 1'b0;
                end
            end
            if (!(f_done && d_done)) begin
                n_tests++; n_fail++;
                $display("FAIL rnd%0d timeout: got if_done=%b dm_done=%b want 1 1", it, f_done, d_done);
            end
            idle_inputs();
            tick();
        end
    endtask

    initial begin
        logic [31:0] v;
        for (int i = 0; i < 4096; i++) begin
            v = $urandom();
            mem[i] <= v;
            ref_mem[i] = v;
        end
        mem[1] <= 32'h2008_0005;
        ref_mem[1] = 32'h2008_0005;
        test_reset();
        test_fetch();
        test_store_load();
        test_contention();
        test_addr_change();
        test_reset_midflight();
        test_protect();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
